// File: rtl/result_reader_if.sv
// Output stream of the result reader: valid/ready handshake with an 8-bit payload and an end-of-frame marker.
interface result_reader_if;
  logic       oValid;
  logic       iReady;
  logic [7:0] oData;
  logic       oLast;

  modport master (output oValid, output oData, output oLast, input iReady);
  modport slave  (input oValid, input oData, input oLast, output iReady);
endinterface

// File: rtl/result_reader.sv
// Streams the 1-bit result memory in raster order through a 2-entry skid FIFO; first item 3 cycles after iStart.
// Optional RESULT_READER_PACK_EN packs 8 pixels LSB-first into each byte; otherwise one pixel per item.
module result_reader #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  input  logic                   iResultData,
  output logic                   oBusy,
  output logic                   oDone,
  result_reader_if.master        stream
);

  localparam int AW = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] rd_addr;
  logic          inflight;
  logic          inflight_last;
  logic [8:0]    fifo_mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          busy;
  logic          done;

  logic          pop;
  logic          issue;
  logic          push;
  logic [7:0]    push_dat;
  logic [8:0]    head;

`ifdef RESULT_READER_PACK_EN
  logic [2:0]    inflight_idx;
  logic [6:0]    pack_sr;

  // Only the eighth pixel of a group produces a FIFO entry.
  assign push     = inflight && (inflight_idx == 3'd7);
  assign push_dat = {iResultData, pack_sr};
`else
  assign push     = inflight;
  assign push_dat = {7'b0, iResultData};
`endif

  assign head  = fifo_mem[rd_ptr];
  assign pop   = stream.oValid & stream.iReady;
  // An outstanding RAM read is counted as occupied, so a push never lands on a full FIFO.
  assign issue = (state == READ) &&
                 (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign stream.oValid = (count != 2'd0);
  assign stream.oData  = stream.oValid ? head[7:0] : 8'h00;
  assign stream.oLast  = stream.oValid & head[8];

  assign {oResultRow, oResultCol} = rd_addr;
  assign oBusy = busy;
  assign oDone = done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef RESULT_READER_PACK_EN
      inflight_idx  <= 3'd0;
      pack_sr       <= 7'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            state   <= READ;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        READ: begin
          if (issue && (rd_addr == LAST_ADDR)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && stream.oLast) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (iStart) begin
            state   <= READ;
            rd_addr <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // The final address is held so the counter never wraps inside a frame.
      if (issue && (rd_addr != LAST_ADDR)) begin
        rd_addr <= rd_addr + 1'b1;
      end

      inflight      <= issue;
      inflight_last <= issue && (rd_addr == LAST_ADDR);
`ifdef RESULT_READER_PACK_EN
      if (issue) begin
        inflight_idx <= rd_addr[2:0];
      end
      if (inflight) begin
        pack_sr <= {iResultData, pack_sr[6:1]};
      end
`endif

      if (push) begin
        fifo_mem[wr_ptr] <= {inflight_last, push_dat};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
